// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: GF(2^8) arithmetic, S-boxes, key-word helpers,
// round transforms and the round constants used by the iterative cores.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4
    } aes_state_e;

    typedef enum logic {
        KEY_FWD = 1'b0,
        KEY_INV = 1'b1
    } key_dir_e;

    // Indexed directly by the 4-bit round counter; unused slots read as zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = gf_mul(a, a);
        for (int i = 1; i < 8; i++) begin
            r  = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box computed as the affine transform of the field inverse.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte i of the state sits at [127-8i -: 8]; column c = i/4, row r = i%4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule, forward (round i -> i+1) or
// inverse (round i -> i-1), using the rcon of the higher-numbered round.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    input  key_dir_e     dir,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;

    // Both directions are computed; dir picks which one drives the output.
    always_comb begin
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];

        n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h0};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;

        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h0};

        rk_next = (dir == KEY_FWD) ? {n0, n1, n2, n3} : {p0, p1, p2, p3};
    end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption: expands the key forward to round key 10,
// then runs one inverse round per clock while stepping the key back to 0.
//
// Handshake: a block is accepted on the rising edge where ready=1 and
// next=1; next is ignored while ready=0. result_valid pulses for one cycle
// (the first idle cycle) when result updates; result holds until the next
// completion. state is a debug view of the controller.
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [127:0] block,
    input  logic [127:0] key,
    output logic         ready,
    output logic [127:0] result,
    output logic         result_valid,
    output aes_state_e   state
);

    aes_state_e   state_nxt;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   cnt;
    logic [127:0] key_next;
    key_dir_e     key_dir;
    logic [7:0]   key_rcon;
    logic [127:0] inv_core;

    aes_key_step u_key_step (
        .rk      (rk),
        .rcon    (key_rcon),
        .dir     (key_dir),
        .rk_next (key_next)
    );

    // Key-step control and the shared InvShiftRows/InvSubBytes/AddRoundKey path.
    always_comb begin
        key_dir  = (state == ST_KEYEXP) ? KEY_FWD : KEY_INV;
        key_rcon = (state == ST_INIT) ? RCON[10] : RCON[cnt];
        inv_core = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (next) state_nxt = ST_KEYEXP;
            ST_KEYEXP: if (cnt == 4'd10) state_nxt = ST_INIT;
            ST_INIT:   state_nxt = ST_ROUND;
            ST_ROUND:  if (cnt == 4'd1) state_nxt = ST_FINAL;
            ST_FINAL:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Data path, round counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st           <= '0;
            rk           <= '0;
            cnt          <= 4'd0;
            ready        <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (next) begin
                        st    <= block;
                        rk    <= key;
                        cnt   <= 4'd1;
                        ready <= 1'b0;
                    end
                end
                ST_KEYEXP: begin
                    rk  <= key_next;
                    cnt <= cnt + 4'd1;
                end
                ST_INIT: begin
                    st  <= st ^ rk;
                    rk  <= key_next;
                    cnt <= 4'd9;
                end
                ST_ROUND: begin
                    st  <= inv_mix_columns(inv_core);
                    rk  <= key_next;
                    cnt <= cnt - 4'd1;
                end
                ST_FINAL: begin
                    result       <= inv_core;
                    result_valid <= 1'b1;
                    ready        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: known-answer vectors, busy rejection,
// back-to-back operation, mid-operation reset and input hold.
module tb_aes_decrypt;
    import aes_pkg::*;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic [127:0] block;
    logic [127:0] key;
    logic         ready;
    logic [127:0] result;
    logic         result_valid;
    aes_state_e   state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [127:0] init_rk;

    aes_decrypt dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .next         (next),
        .block        (block),
        .key          (key),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Drive one request once the core is ready; record the expected result.
    task automatic send(input logic [127:0] blk, input logic [127:0] k, input logic [127:0] exp);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("send_ready_timeout", 128'(ready), 128'(1));
        block = blk;
        key   = k;
        next  = 1'b1;
        @(negedge clk);
        next = 1'b0;
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
    endtask

    // Wait for the completion pulse; report busy cycles, pulse cycle and
    // how often result moved before the pulse.
    task automatic wait_done(output int low, output int t, output int hold_err);
        int n;
        logic [127:0] ref_val;
        low      = 0;
        hold_err = 0;
        n        = 0;
        t        = -1;
        ref_val  = result;
        while (!result_valid && n < 100) begin
            if (!ready) low++;
            if (result !== ref_val) hold_err++;
            @(negedge clk);
            n++;
        end
        if (result_valid) t = cyc;
        else check("done_timeout", 128'(result_valid), 128'(1));
    endtask

    // Scoreboard: compare each completion with the oldest outstanding request.
    always @(negedge clk) begin
        if (reset_n && result_valid) begin
            check("ready_on_valid", 128'(ready), 128'(1));
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 128'(result_valid), 128'(0));
            end else begin
                check("result", result, exp_q.pop_front());
                check("latency", 128'(cyc - acc_q.pop_front()), 128'(21));
            end
        end
        if (reset_n && state == ST_INIT) init_rk = dut.rk;
    end

    initial begin
        int low, t1, t2, herr, herr2;
        reset_n = 1'b0;
        next    = 1'b0;
        block   = '0;
        key     = '0;
        init_rk = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_valid", 128'(result_valid), 128'(0));
        check("rst_result", result, 128'h0);
        check("rst_state", 128'(state), 128'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1
        send(C1_CT, C1_KEY, C1_PT);
        wait_done(low, t1, herr);
        check("c1_ready_low_cycles", 128'(low), 128'(21));
        check("c1_rk10", init_rk, C1_RK10);
        @(negedge clk);
        check("valid_one_cycle", 128'(result_valid), 128'(0));
        check("result_hold_idle", result, C1_PT);

        // FIPS-197 App. B
        send(B_CT, B_KEY, B_PT);
        wait_done(low, t1, herr);
        check("b_rk10", init_rk, B_RK10);

        // busy rejection: junk requests at cycles 5 and 15
        send(C1_CT, C1_KEY, C1_PT);
        repeat (4) @(negedge clk);
        block = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
        next  = 1'b1;
        @(negedge clk);
        next  = 1'b0;
        check("busy_ready_low", 128'(ready), 128'(0));
        repeat (9) @(negedge clk);
        block = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
        next  = 1'b1;
        @(negedge clk);
        next  = 1'b0;
        wait_done(low, t1, herr);
        @(negedge clk);

        // back-to-back: C.1 then App. B, second accepted in the valid cycle
        send(C1_CT, C1_KEY, C1_PT);
        wait_done(low, t1, herr);
        send(B_CT, B_KEY, B_PT);
        wait_done(low, t2, herr2);
        check("b2b_spacing", 128'(t2 - t1), 128'(22));
        check("b2b_result_hold", 128'(herr2), 128'(0));

        // identical back-to-back blocks each produce a pulse
        send(C1_CT, C1_KEY, C1_PT);
        wait_done(low, t1, herr);
        send(C1_CT, C1_KEY, C1_PT);
        wait_done(low, t2, herr2);
        check("same_spacing", 128'(t2 - t1), 128'(22));
        @(negedge clk);

        // reset mid-operation at cycle 12
        send(B_CT, B_KEY, B_PT);
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        #1;
        check("midrst_ready", 128'(ready), 128'(1));
        check("midrst_result", result, 128'h0);
        check("midrst_valid", 128'(result_valid), 128'(0));
        check("midrst_state", 128'(state), 128'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(C1_CT, C1_KEY, C1_PT);
        wait_done(low, t1, herr);
        check("post_rst_low_cycles", 128'(low), 128'(21));
        @(negedge clk);

        // input hold: inputs change right after accept
        send(C1_CT, C1_KEY, C1_PT);
        block = B_CT;
        key   = B_KEY;
        wait_done(low, t1, herr);

        repeat (30) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_decrypt.md
# aes_decrypt

Iterative AES-128 decryption core, the inverse counterpart of the team's encrypt block. It accepts one 128-bit ciphertext block and one 128-bit cipher key, and returns the plaintext block. The core expands the key forward on the fly to reach round key 10, then runs the decryption rounds while walking the key schedule backwards. It processes one round per clock and has no key storage beyond the current round key.

## Interface
Parameters: none. AES-128 only (Nk=4, Nr=10).

Ports:
- clk  in  1  — single clock; all state updates on rising edge
- reset_n  in  1  — asynchronous, active-low reset
- next  in  1  — start request; sampled only while ready=1
- block  in  128  — ciphertext; byte 0 in [127:120], column-major (FIPS-197 ordering)
- key  in  128  — cipher key, same byte ordering
- ready  out  1  — core idle and able to accept next
- result  out  128  — plaintext; holds its value until the next completion
- result_valid  out  1  — one-cycle pulse when result updates

## Operation
- States: IDLE, KEYEXP, INIT, ROUND, FINAL. Round counter cnt is 4 bits. Registers: st (128), rk (128).
- IDLE: ready=1. On next=1, capture block into st and key into rk, set cnt=1, set ready=0, and go to KEYEXP.
- KEYEXP: rk <= fwd_step(rk, rcon[cnt]); cnt++. After the cycle with cnt=10, go to INIT. At that point rk = round key 10.
- INIT: st <= st ^ rk; rk <= inv_step(rk, rcon[10]); cnt <= 9; go to ROUND.
- ROUND: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk); rk <= inv_step(rk, rcon[cnt]); cnt--. After the cycle with cnt=1, go to FINAL. At that point rk = round key 0.
- FINAL: result <= InvSubBytes(InvShiftRows(st)) ^ rk; result_valid <= 1; ready <= 1; go to IDLE.
- Forward key step, with rk = {w0,w1,w2,w3}:
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2
- Inverse key step:
  - p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}
- RotWord({a,b,c,d}) = {b,c,d,a}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- InvMixColumns uses coefficients 0e,0b,0d,09 over GF(2^8) with reduction polynomial 0x11b.
- next while ready=0 is ignored; there is no queueing.
- block and key are sampled only on the accepting edge. Later changes have no effect on the operation in flight.

## Timing
- Reset values: ready=1, result_valid=0, result=128'h0, state=IDLE, st=0, rk=0, cnt=0.
- Latency: with the accept edge as edge 0, KEYEXP occupies edges 1–10, INIT edge 11, ROUND edges 12–20, and FINAL edge 21.
  - result and result_valid are visible after edge 21.
  - ready is low for 21 cycles.
- result_valid is high for exactly one cycle, the first IDLE cycle. ready=1 in that same cycle.
- next asserted in the result_valid cycle is accepted: back-to-back throughput is one block per 22 cycles.
- result stays stable until the following FINAL edge.
- Reset asserted mid-operation aborts immediately to reset values. No result_valid pulse occurs for the aborted block.
- Identical back-to-back blocks produce a fresh result_valid pulse each time.

## Structure
- aes_pkg holds:
  - sbox and inv_sbox as functions, or as constant arrays of 256×8
  - rcon array
  - xtime and gf_mul helpers
  - SubWord and RotWord
  - state enum
- The encrypt block should be migrated to import the same package.
- One sub-module, aes_key_step: combinational, with inputs rk, rcon and a dir select (fwd/inv), producing the next rk.
- The data path, counter and FSM live in aes_decrypt.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, block 69c4e0d86a7b0430d8cdb78070b4c55a → result 00112233445566778899aabbccddeeff and result_valid pulse exactly 21 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3925841d02dc09fbdc118597196a0b32 → result 3243f6a8885a308d313198a2e0370734. Internally, rk = d014f9a8c9ee2589e13f0cc8b6630ca6 on entering INIT.
- Busy rejection: pulse next with a different block/key at cycles 5 and 15 of an operation → ignored, and the first result is unchanged and on time.
- Back-to-back: assert next in the result_valid cycle with the C.1 vector, then the App. B vector → two correct results 22 cycles apart. result holds the first value until the second pulse.
- Reset mid-operation: assert reset_n=0 at cycle 12 → ready=1, result=0, result_valid=0 immediately. A following C.1 run completes correctly.
- Input hold: change block and key on the cycle after accept → result still equals the C.1 plaintext.
